// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: command/result bundle for the serial adder (SUB_MODE_EN adds 'sub')
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
`ifdef SUB_MODE_EN
  logic sub;
`endif
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum;
  logic cout;
`ifdef SUB_MODE_EN
  modport master(output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave(input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master(output start, a, b, cin, input busy, done, sum, cout);
  modport slave(input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer over one 1-bit full adder (SUB_MODE_EN enables subtract)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_adder_ctrl_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] ra, rb, res;
  logic carry, z, co, sb;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] ext;
`ifdef SUB_MODE_EN
  assign sb = io.sub;
`else
  assign sb = 1'b0;
`endif
  assign z = ra[0] ^ rb[0] ^ carry;
  assign co = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
  assign ext = {z, res};
  assign io.busy = state == RUN;
  assign io.done = state == DONE;
  // sequencer: capture on accepted start, shift one bit per RUN cycle, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      res <= '0;
      carry <= 1'b0;
      cnt <= '0;
      io.sum <= '0;
      io.cout <= 1'b0;
    end else if (state != RUN) begin
      if (io.start) begin
        ra <= io.a;
        rb <= sb ? ~io.b : io.b;
        carry <= sb ? 1'b1 : io.cin;
        cnt <= '0;
        state <= RUN;
      end else begin
        state <= IDLE;
      end
    end else begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      res <= ext[WIDTH:1];
      carry <= co;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= DONE;
        io.sum <= ext[WIDTH:1];
        io.cout <= co;
      end
    end
  end
endmodule
